// File: rtl/cam_link_pkg.sv
// Shared definitions for the AXI4-Stream to CameraLink transmitter: bus bit
// positions, FSM state encoding and the output word packer.
package cam_link_pkg;

  localparam int PIX_W     = 24;
  localparam int LVAL_BIT  = 24;
  localparam int FVAL_BIT  = 25;
  localparam int DVAL_BIT  = 26;
  localparam int SPARE_BIT = 27;

  typedef enum logic [2:0] {
    IDLE,
    FSETUP,
    LINE,
    HBLANK,
    VBLANK
  } state_t;

  function automatic logic [27:0] build_word(input logic fval,
                                             input logic lval,
                                             input logic dval,
                                             input logic [PIX_W-1:0] pix);
    logic [27:0] w;
    w            = '0;
    w[PIX_W-1:0] = pix;
    w[LVAL_BIT]  = lval;
    w[FVAL_BIT]  = fval;
    w[DVAL_BIT]  = dval;
    w[SPARE_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/axi4s_to_cam_blank_cnt.sv
// Loadable down-counter shared by the frame-setup, horizontal and vertical
// blanking intervals; done is high on the last cycle of the loaded interval.
module cam_blank_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/axi4s_to_cam_out.sv
// AXI4-Stream video slave driving a 28-bit CameraLink-style parallel bus with
// FVAL/LVAL/DVAL strobes. Define CAM_TX_STATS_EN to add frame/drop counters.
import cam_link_pkg::*;

module axi4s_to_cam_out #(
  parameter int LINES_PER_FRAME = 10,
  parameter int H_BLANK         = 5,
  parameter int V_BLANK         = 5,
  parameter int FV_SETUP        = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [27:0] cam_data_out,
  output logic        frame_err
`ifdef CAM_TX_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
`endif
);

  state_t      state, state_nx;
  logic        first_beat, first_beat_nx;
  logic [15:0] line_cnt, line_cnt_nx;
  logic        ready_c, accept, sof_err, err_nx;
  logic        cnt_load, cnt_done;
  logic [15:0] cnt_val;
  logic [27:0] word_nx;

  // A SOF arriving after the first beat of a frame is refused and aborts it.
  assign sof_err = (state == LINE) & s_axis_tvalid & s_axis_tuser & ~first_beat;
  assign ready_c = (state == IDLE) ? ~s_axis_tuser :
                   (state == LINE) ? ~sof_err      : 1'b0;
  assign s_axis_tready = ready_c & ~areset;
  assign accept        = s_axis_tvalid & s_axis_tready;

  cam_blank_cnt #(.W(16)) u_blank_cnt (
    .clk      (aclk),
    .rst      (areset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_nx      = state;
    first_beat_nx = first_beat;
    line_cnt_nx   = line_cnt;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    word_nx       = '0;
    err_nx        = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_tvalid & s_axis_tuser) begin
          state_nx = FSETUP;
          cnt_load = 1'b1;
          cnt_val  = 16'(FV_SETUP);
        end
      end
      FSETUP: begin
        word_nx = build_word(1'b1, 1'b0, 1'b0, '0);
        if (cnt_done) begin
          state_nx      = LINE;
          first_beat_nx = 1'b1;
        end
      end
      LINE: begin
        word_nx = build_word(1'b1, 1'b1, accept, accept ? s_axis_tdata : '0);
        if (sof_err) begin
          err_nx   = 1'b1;
          state_nx = VBLANK;
          cnt_load = 1'b1;
          cnt_val  = 16'(V_BLANK);
        end else if (accept) begin
          first_beat_nx = 1'b0;
          if (s_axis_tlast) begin
            line_cnt_nx = line_cnt + 16'd1;
            cnt_load    = 1'b1;
            if (line_cnt == 16'(LINES_PER_FRAME - 1)) begin
              state_nx = VBLANK;
              cnt_val  = 16'(V_BLANK);
            end else begin
              state_nx = HBLANK;
              cnt_val  = 16'(H_BLANK);
            end
          end
        end
      end
      HBLANK: begin
        word_nx = build_word(1'b1, 1'b0, 1'b0, '0);
        if (cnt_done) state_nx = LINE;
      end
      VBLANK: begin
        line_cnt_nx = '0;
        if (cnt_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      first_beat   <= 1'b0;
      line_cnt     <= '0;
      cam_data_out <= '0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_nx;
      first_beat   <= first_beat_nx;
      line_cnt     <= line_cnt_nx;
      cam_data_out <= word_nx;
      frame_err    <= err_nx;
    end
  end

`ifdef CAM_TX_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if ((state_nx == VBLANK) && (state != VBLANK)) frame_count <= frame_count + 16'd1;
      if ((state == IDLE) && accept)                 drop_count  <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi4s_to_cam_out.sv
// Self-checking bench for axi4s_to_cam_out: frames are driven over AXIS and the
// recorded output word stream is compared against a trace built from the bus rules.
module tb_axi4s_to_cam_out;

  localparam int LPF = 2;
  localparam int HB  = 3;
  localparam int VB  = 5;
  localparam int FS  = 2;

  localparam logic [28:0] W_L = 29'h0100_0000;
  localparam logic [28:0] W_F = 29'h0200_0000;
  localparam logic [28:0] W_D = 29'h0400_0000;
  localparam logic [28:0] W_E = 29'h1000_0000;

  logic        aclk;
  logic        areset;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic [27:0] cam_data_out;
  logic        frame_err;
`ifdef CAM_TX_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
`endif

  axi4s_to_cam_out #(
    .LINES_PER_FRAME (LPF),
    .H_BLANK         (HB),
    .V_BLANK         (VB),
    .FV_SETUP        (FS)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .cam_data_out  (cam_data_out),
    .frame_err     (frame_err)
`ifdef CAM_TX_STATS_EN
    ,
    .frame_count   (frame_count),
    .drop_count    (drop_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  // Every cycle's {frame_err, cam_data_out} while recording is enabled.
  logic [28:0] log_q[$];
  logic [28:0] exp_q[$];
  bit          rec = 1'b0;
  always @(negedge aclk) if (rec) log_q.push_back({frame_err, cam_data_out});

  int          tests = 0;
  int          fails = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;
  logic [23:0] seq_pix = 24'd1;

  task automatic start_rec();
    log_q.delete();
    exp_q.delete();
    rec = 1'b1;
  endtask

  task automatic exp_fill(input logic [28:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
  endtask

  // Drives one beat and holds it until the handshake completes.
  task automatic send_px(input logic [23:0] d, input logic u, input logic l);
    logic r;
    bit   got;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      r = s_axis_tready;
      @(posedge aclk);
      #1;
      if (r) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake_timeout: beat %h not accepted within 200 cycles, required acceptance", d);
    end
  endtask

  task automatic send_pix(input logic [23:0] d, input logic u, input logic l);
    send_px(d, u, l);
    exp_q.push_back(W_F | W_L | W_D | {5'b0, d});
  endtask

  task automatic send_frame(input int n0, input int n1, input int stall_k, input bit rnd);
    int          lens[2];
    logic [23:0] d;
    lens[0] = n0;
    lens[1] = n1;
    exp_fill(W_F, FS);
    for (int li = 0; li < LPF; li++) begin
      for (int k = 0; k < lens[li]; k++) begin
        if (rnd) d = 24'($urandom);
        else begin
          d = seq_pix;
          seq_pix = seq_pix + 24'd1;
        end
        send_pix(d, (li == 0) && (k == 0), k == lens[li] - 1);
        if ((li == 0) && (k == stall_k) && (k < lens[li] - 1)) begin
          s_axis_tvalid = 1'b0;
          repeat (2) @(posedge aclk);
          #1;
          exp_fill(W_F | W_L, 2);
        end
      end
      if (li < LPF - 1) exp_fill(W_F, HB);
    end
    exp_frames++;
  endtask

  task automatic end_frame();
    s_axis_tvalid = 1'b0;
    exp_fill('0, VB);
    repeat (VB + 3) @(posedge aclk);
    #1;
  endtask

  // Aligns the log on its first non-idle word and returns the first
  // differing index into the expected trace, or -1 when all of it matches.
  function automatic int first_diff(output logic [28:0] got, output logic [28:0] want);
    int s;
    s    = -1;
    got  = 'x;
    want = 'x;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i] != '0) begin
        s = i;
        break;
      end
    end
    if (exp_q.size() == 0) return -1;
    want = exp_q[0];
    if (s < 0) return 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      want = exp_q[i];
      if (s + i >= log_q.size()) return i;
      got = log_q[s + i];
      if (got !== want) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    #12;
    tests++;
    if (cam_data_out !== 28'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: cam_data_out=%h required 0", cam_data_out);
    end
    tests++;
    if (s_axis_tready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: tready=%b required 0", s_axis_tready);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_err: frame_err=%b required 0", frame_err);
    end
    #11;
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_nominal();
    logic [28:0] g, w;
    int          d, n;
    start_rec();
    seq_pix = 24'd1;
    send_frame(4, 4, -1, 1'b0);
    s_axis_tvalid = 1'b0;
    exp_fill('0, VB);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (s_axis_tready) break;
      n++;
    end
    repeat (5) @(posedge aclk);
    #1;
    rec = 1'b0;
    d = first_diff(g, w);
    tests++;
    if (d != -1) begin
      fails++;
      $display("[TB] FAIL nominal_trace: word %0d got %h required %h", d, g, w);
    end
    tests++;
    if (n != VB) begin
      fails++;
      $display("[TB] FAIL nominal_ready_return: tready low %0d cycles required %0d", n, VB);
    end
  endtask

  task automatic test_stall();
    logic [28:0] g, w;
    int          d;
    start_rec();
    send_frame(4, 4, 1, 1'b1);
    end_frame();
    rec = 1'b0;
    d = first_diff(g, w);
    tests++;
    if (d != -1) begin
      fails++;
      $display("[TB] FAIL stall_trace: word %0d got %h required %h", d, g, w);
    end
  endtask

  task automatic test_junk();
    int t0, t1, nz;
    start_rec();
    t0 = cyc;
    for (int i = 0; i < 3; i++) send_px(24'($urandom), 1'b0, 1'($urandom));
    t1 = cyc;
    s_axis_tvalid = 1'b0;
    exp_drops += 3;
    repeat (3) @(posedge aclk);
    #1;
    rec = 1'b0;
    nz = 0;
    foreach (log_q[i]) if (log_q[i] !== '0) nz++;
    tests++;
    if (nz != 0) begin
      fails++;
      $display("[TB] FAIL junk_output: %0d non-zero words required 0", nz);
    end
    tests++;
    if (t1 - t0 != 3) begin
      fails++;
      $display("[TB] FAIL junk_accept: 3 beats took %0d cycles required 3", t1 - t0);
    end
`ifdef CAM_TX_STATS_EN
    tests++;
    if (drop_count !== 16'(exp_drops)) begin
      fails++;
      $display("[TB] FAIL junk_drop_count: drop_count=%0d required %0d", drop_count, exp_drops);
    end
`endif
  endtask

  task automatic test_midframe_sof();
    logic [28:0] g, w;
    int          d, nerr;
    start_rec();
    exp_fill(W_F, FS);
    send_pix(24'($urandom), 1'b1, 1'b0);
    send_pix(24'($urandom), 1'b0, 1'b0);
    exp_q.push_back(W_E | W_F | W_L);
    exp_fill('0, VB + 1);
    exp_frames++;
    exp_fill(W_F, FS);
    send_pix(24'($urandom), 1'b1, 1'b0);
    send_pix(24'($urandom), 1'b0, 1'b0);
    send_pix(24'($urandom), 1'b0, 1'b0);
    send_pix(24'($urandom), 1'b0, 1'b1);
    exp_fill(W_F, HB);
    for (int k = 0; k < 4; k++) send_pix(24'($urandom), 1'b0, k == 3);
    exp_frames++;
    end_frame();
    rec = 1'b0;
    d = first_diff(g, w);
    tests++;
    if (d != -1) begin
      fails++;
      $display("[TB] FAIL midsof_trace: word %0d got %h required %h", d, g, w);
    end
    nerr = 0;
    foreach (log_q[i]) if (log_q[i][28]) nerr++;
    tests++;
    if (nerr != 1) begin
      fails++;
      $display("[TB] FAIL midsof_err_pulses: %0d frame_err cycles required 1", nerr);
    end
  endtask

  task automatic test_reset_midline();
    logic [28:0] g, w, want_px;
    logic [23:0] p2;
    int          d, t0, t1;
    p2 = 24'($urandom);
    send_px(24'($urandom), 1'b1, 1'b0);
    send_px(p2, 1'b0, 1'b0);
    s_axis_tdata = 24'($urandom);
    @(negedge aclk);
    want_px = W_F | W_L | W_D | {5'b0, p2};
    tests++;
    if (cam_data_out !== want_px[27:0]) begin
      fails++;
      $display("[TB] FAIL rst_pre_pixel: cam_data_out=%h required %h", cam_data_out, want_px[27:0]);
    end
    #1;
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    tests++;
    if (cam_data_out !== 28'h0) begin
      fails++;
      $display("[TB] FAIL rst_async_data: cam_data_out=%h required 0", cam_data_out);
    end
    tests++;
    if (s_axis_tready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_async_ready: tready=%b required 0", s_axis_tready);
    end
    #1;
    areset = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    @(posedge aclk);
    #1;
    start_rec();
    t0 = cyc;
    send_px(24'($urandom), 1'b0, 1'b0);
    send_px(24'($urandom), 1'b0, 1'b1);
    t1 = cyc;
    s_axis_tvalid = 1'b0;
    exp_drops += 2;
    tests++;
    if (t1 - t0 != 2) begin
      fails++;
      $display("[TB] FAIL rst_junk_accept: 2 beats took %0d cycles required 2", t1 - t0);
    end
`ifdef CAM_TX_STATS_EN
    tests++;
    if (drop_count !== 16'(exp_drops)) begin
      fails++;
      $display("[TB] FAIL rst_drop_count: drop_count=%0d required %0d", drop_count, exp_drops);
    end
`endif
    repeat (2) @(posedge aclk);
    #1;
    send_frame(3, 2, -1, 1'b1);
    end_frame();
    rec = 1'b0;
    d = first_diff(g, w);
    tests++;
    if (d != -1) begin
      fails++;
      $display("[TB] FAIL rst_frame_trace: word %0d got %h required %h", d, g, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [28:0] g, w;
    int          d;
    start_rec();
    send_frame(1, int'($urandom_range(1, 4)), -1, 1'b1);
    exp_fill('0, VB + 1);
    send_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), -1, 1'b1);
    exp_fill('0, VB + 1);
    send_frame(int'($urandom_range(1, 4)), 1, -1, 1'b1);
    end_frame();
    rec = 1'b0;
    d = first_diff(g, w);
    tests++;
    if (d != -1) begin
      fails++;
      $display("[TB] FAIL b2b_trace: word %0d got %h required %h", d, g, w);
    end
`ifdef CAM_TX_STATS_EN
    tests++;
    if (frame_count !== 16'(exp_frames)) begin
      fails++;
      $display("[TB] FAIL b2b_frame_count: frame_count=%0d required %0d", frame_count, exp_frames);
    end
`endif
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_junk();
    test_midframe_sof();
    test_reset_midline();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
